// File: rtl/mix_column_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_simd_pkg                                                          |
// | Shared AES SIMD types, MixColumns coefficients and GF(2^8) helpers.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package aes_simd_pkg;

    typedef enum logic [1:0] {MC_IDLE, MC_MULT, MC_DONE} mc_state_t;

    localparam logic [3:0] MC_FWD_COEF [4] = '{4'd2, 4'd3, 4'd1, 4'd1};
    localparam logic [3:0] MC_INV_COEF [4] = '{4'd14, 4'd11, 4'd13, 4'd9};
    localparam logic [7:0] AES_POLY = 8'h1B;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_column_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mix_column_seq_ctrl_if                                                |
// | Column-in / column-out valid-ready bus of the MixColumns engine.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface mix_column_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_col;
    logic        in_inv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
    logic        busy;

    modport master (
        output in_valid, in_col, in_inv, out_ready,
        input  in_ready, out_valid, out_col, busy
    );

    modport slave (
        input  in_valid, in_col, in_inv, out_ready,
        output in_ready, out_valid, out_col, busy
    );
endinterface
`default_nettype wire

// File: rtl/mix_column_seq_ctrl_gf_mul_xtime.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf_mul_xtime                                                          |
// | Combinational GF(2^8) byte multiply by a MixColumns coefficient.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gf_mul_xtime
    import aes_simd_pkg::*;
(
    input  logic [7:0] a,
    input  logic [3:0] coef,
    output logic [7:0] p
);
    logic [7:0] w_x1;
    logic [7:0] w_x2;
    logic [7:0] w_x3;
    logic       w_supported;

    assign w_x1 = xtime(a);
    assign w_x2 = xtime(w_x1);
    assign w_x3 = xtime(w_x2);

    // Only the coefficients of the two AES matrices produce a product.
    always_comb begin
        w_supported = 1'b0;
        case (coef)
            4'd1, 4'd2, 4'd3, 4'd9, 4'd11, 4'd13, 4'd14: w_supported = 1'b1;
            default:                                      w_supported = 1'b0;
        endcase
    end

    assign p = w_supported ? (({8{coef[0]}} & a)    ^
                              ({8{coef[1]}} & w_x1) ^
                              ({8{coef[2]}} & w_x2) ^
                              ({8{coef[3]}} & w_x3)) : 8'h00;
endmodule
`default_nettype wire

// File: rtl/mix_column_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mix_column_seq_ctrl                                                   |
// | Sequential MixColumns/InvMixColumns engine, LANES multipliers/cycle.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mix_column_seq_ctrl
    import aes_simd_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mix_column_seq_ctrl_if.slave  bus
);
    localparam logic [3:0] c_STEP = 4'(LANES);
    localparam logic [3:0] c_LAST = 4'(16 - LANES);

    mc_state_t   r_state;
    mc_state_t   w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_col;
    logic        r_inv;
    logic [7:0]  r_acc;
    logic [31:0] r_res;

    logic [7:0]  w_prod [LANES];
    logic [7:0]  w_sum;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_row_end;
    logic        w_wrap;
    logic [1:0]  w_row;

    assign w_in_ready = (r_state == MC_IDLE) || ((r_state == MC_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_row      = r_cnt[3:2];
    // Batches are LANES-aligned, so every lane of a cycle falls in one row.
    assign w_row_end  = (r_cnt[1:0] + 2'(LANES - 1)) == 2'b11;
    assign w_wrap     = (r_cnt == c_LAST);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [3:0] w_idx;
        logic [1:0] w_sel;
        logic [7:0] w_byte;
        logic [3:0] w_coef;

        assign w_idx  = r_cnt + 4'(g);
        assign w_sel  = w_idx[1:0] - w_idx[3:2];
        assign w_byte = r_col[{~w_idx[1:0], 3'b000} +: 8];
        assign w_coef = r_inv ? MC_INV_COEF[w_sel] : MC_FWD_COEF[w_sel];

        gf_mul_xtime u_gf (
            .a    (w_byte),
            .coef (w_coef),
            .p    (w_prod[g])
        );
    end

    always_comb begin
        w_sum = 8'h00;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum ^ w_prod[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MC_IDLE: if (w_accept) w_next = MC_MULT;
            MC_MULT: if (w_wrap)   w_next = MC_DONE;
            MC_DONE: if (bus.out_ready) w_next = w_accept ? MC_MULT : MC_IDLE;
            default: w_next = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
            r_col <= 32'h0;
            r_inv <= 1'b0;
            r_acc <= 8'h00;
            r_res <= 32'h0;
        end else if (w_accept) begin
            r_cnt <= 4'd0;
            r_col <= bus.in_col;
            r_inv <= bus.in_inv;
            r_acc <= 8'h00;
        end else if (r_state == MC_MULT) begin
            r_cnt <= r_cnt + c_STEP;
            if (w_row_end) begin
                r_res[{~w_row, 3'b000} +: 8] <= r_acc ^ w_sum;
                r_acc                        <= 8'h00;
            end else begin
                r_acc <= r_acc ^ w_sum;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == MC_DONE);
    assign bus.busy      = (r_state != MC_IDLE);
    assign bus.out_col   = r_res;
endmodule
`default_nettype wire
